// File: rtl/entradas_pkg.sv
// Button event codes shared by the input stage and its consumers,
// plus the helper that maps a direction to its 180-degree opposite.
package entradas_pkg;

   typedef logic [2:0] cod_t;

   localparam cod_t COD_NINGUNO = 3'd0;
   localparam cod_t COD_ARRIBA  = 3'd1;
   localparam cod_t COD_ABAJO   = 3'd2;
   localparam cod_t COD_IZQ     = 3'd3;
   localparam cod_t COD_DER     = 3'd4;
   localparam cod_t COD_PAUSA   = 3'd5;

   function automatic cod_t opuesto(input cod_t codigo);
      case (codigo)
         COD_ARRIBA: opuesto = COD_ABAJO;
         COD_ABAJO:  opuesto = COD_ARRIBA;
         COD_IZQ:    opuesto = COD_DER;
         COD_DER:    opuesto = COD_IZQ;
         default:    opuesto = COD_NINGUNO;
      endcase
   endfunction

endpackage

// File: rtl/gestor_botones_antirrebote.sv
// One button channel: 2-flop synchroniser then a stability filter; raw edge -> stable
// in 2+DEBOUNCE_CYCLES cycles, no backpressure (DEBOUNCE_CYCLES=0 passes the synchronised level).
module antirrebote #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic stable
);

   logic s1, s2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_directo
         assign stable = s2;
      end else begin : g_filtro
         localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
         localparam logic [CW-1:0] LIMITE = CW'(DEBOUNCE_CYCLES - 1);

         logic [CW-1:0] cnt;
         logic          nivel;

         // cnt holds how many consecutive samples disagreed with nivel, minus the current one
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cnt   <= '0;
               nivel <= 1'b0;
            end else if (s2 == nivel) begin
               cnt <= '0;
            end else if (cnt == LIMITE) begin
               nivel <= s2;
               cnt   <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end

         assign stable = nivel;
      end
   endgenerate

endmodule

// File: rtl/gestor_botones.sv
// Debounced button presses -> snake rules -> event FIFO; stable edge -> evento_valid in 2 cycles.
// Consumer stalls with evento_ready=0; events arriving at a full queue are dropped (desborde).
module gestor_botones
   import entradas_pkg::*;
#(
   parameter int  N_BOTONES        = 5,
   parameter int  DEBOUNCE_CYCLES  = 4,
   parameter int  FIFO_DEPTH       = 4,
   parameter int  RECHAZAR_REVERSA = 1,
   localparam int CODE_W           = $clog2(N_BOTONES + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_BOTONES-1:0] botones_raw,
   output logic                 evento_valid,
   output logic [CODE_W-1:0]    evento_codigo,
   input  logic                 evento_ready,
   output logic [CODE_W-1:0]    boton_pres,
   output logic                 pausa_activa,
   output logic                 rechazo,
   output logic                 desborde
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [N_BOTONES-1:0] estable, estable_q, flanco;
   logic                 armado, hay_pulsacion;
   logic                 es_pausa, es_dir, reversa, aceptado, descartado;
   int                   idx;
   cod_t                 cod_dir, ultima_dir;
   logic                 acc_vld;
   logic [CODE_W-1:0]    acc_cod;

   logic [CODE_W-1:0]    mem [FIFO_DEPTH];
   logic [AW:0]          wr_ptr, rd_ptr;
   logic                 vacia, llena, push, pop;

   for (genvar g = 0; g < N_BOTONES; g++) begin : g_canal
      antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_antirrebote (
         .clk    (clk),
         .rst_n  (rst_n),
         .raw    (botones_raw[g]),
         .stable (estable[g])
      );
   end

   assign flanco = estable & ~estable_q;

   // Descending scan so the lowest rising channel is the one left in idx
   always_comb begin
      hay_pulsacion = 1'b0;
      idx           = 0;
      for (int i = N_BOTONES - 1; i >= 0; i--) begin
         if (armado && flanco[i]) begin
            hay_pulsacion = 1'b1;
            idx           = i;
         end
      end
   end

   always_comb begin
      cod_dir    = cod_t'(idx + 1);
      es_pausa   = (idx + 1 == int'(COD_PAUSA));
      es_dir     = (idx + 1 < int'(COD_PAUSA));
      reversa    = (RECHAZAR_REVERSA != 0) && (ultima_dir != COD_NINGUNO) &&
                   (opuesto(ultima_dir) == cod_dir);
      descartado = hay_pulsacion && es_dir && (pausa_activa || reversa);
      aceptado   = hay_pulsacion && !descartado;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estable_q    <= '0;
         armado       <= 1'b1;
         ultima_dir   <= COD_NINGUNO;
         pausa_activa <= 1'b0;
         boton_pres   <= '0;
         rechazo      <= 1'b0;
         acc_vld      <= 1'b0;
         acc_cod      <= '0;
      end else begin
         estable_q <= estable;
         armado    <= (estable == '0) || (armado && !hay_pulsacion);
         rechazo   <= descartado;
         acc_vld   <= aceptado;
         if (aceptado) begin
            acc_cod    <= CODE_W'(idx + 1);
            boton_pres <= CODE_W'(idx + 1);
         end
         if (aceptado && es_pausa) pausa_activa <= ~pausa_activa;
         if (aceptado && es_dir) ultima_dir <= cod_dir;
      end
   end

   // Extra pointer bit tells full from empty when the indices match
   assign vacia = (wr_ptr == rd_ptr);
   assign llena = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop   = !vacia && evento_ready;
   assign push  = acc_vld && (!llena || pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         desborde <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         desborde <= acc_vld && llena && !pop;
         if (push) begin
            mem[wr_ptr[AW-1:0]] <= acc_cod;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   assign evento_valid  = !vacia;
   assign evento_codigo = vacia ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_gestor_botones.sv
// Random and directed stimulus for gestor_botones, checked every cycle against a
// queue-based reference model of the button rules.
module tb_gestor_botones;

   localparam int N     = 5;
   localparam int DC    = 4;
   localparam int DEPTH = 4;
   localparam int CW    = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  botones_raw;
   logic          evento_valid;
   logic [CW-1:0] evento_codigo;
   logic          evento_ready;
   logic [CW-1:0] boton_pres;
   logic          pausa_activa;
   logic          rechazo;
   logic          desborde;

   gestor_botones #(
      .N_BOTONES        (N),
      .DEBOUNCE_CYCLES  (DC),
      .FIFO_DEPTH       (DEPTH),
      .RECHAZAR_REVERSA (1)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .botones_raw   (botones_raw),
      .evento_valid  (evento_valid),
      .evento_codigo (evento_codigo),
      .evento_ready  (evento_ready),
      .boton_pres    (boton_pres),
      .pausa_activa  (pausa_activa),
      .rechazo       (rechazo),
      .desborde      (desborde)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int obs[$];
   bit vio_rech, vio_desb;

   // reference model state
   logic [N-1:0] m_hist[$];
   logic [N-1:0] m_est, m_est_prev;
   bit           m_armado, m_pausa, m_rech, m_desb;
   int           m_ultima, m_pres, m_pend;
   int           m_cola[$];

   task automatic comprobar(input string tag, input int observado, input int esperado);
      n_checks++;
      if (observado !== esperado) begin
         n_errors++;
         $display("FAIL %s: observed %0d expected %0d", tag, observado, esperado);
      end
   endtask

   function automatic void model_reset();
      m_hist.delete();
      for (int i = 0; i < DC + 2; i++) m_hist.push_back('0);
      m_est = '0; m_est_prev = '0;
      m_armado = 1; m_pausa = 0; m_rech = 0; m_desb = 0;
      m_ultima = 0; m_pres = 0; m_pend = 0;
      m_cola.delete();
   endfunction

   function automatic void model_edge(input logic [N-1:0] raw, input logic ready);
      int code;
      bit todos;
      m_desb = 0; m_rech = 0; code = 0;
      if (m_cola.size() > 0 && ready) void'(m_cola.pop_front());
      if (m_pend != 0) begin
         if (m_cola.size() < DEPTH) m_cola.push_back(m_pend);
         else m_desb = 1;
      end
      m_pend = 0;
      if (m_armado)
         for (int i = 0; i < N; i++)
            if (code == 0 && m_est[i] && !m_est_prev[i]) code = i + 1;
      if (code == 5) begin
         m_pausa = !m_pausa;
         m_pend = code; m_pres = code;
      end else if (code >= 1 && code <= 4) begin
         if (m_pausa) m_rech = 1;
         else if (m_ultima != 0 && code == ((m_ultima % 2 == 1) ? m_ultima + 1 : m_ultima - 1))
            m_rech = 1;
         else begin
            m_pend = code; m_pres = code; m_ultima = code;
         end
      end else if (code != 0) begin
         m_pend = code; m_pres = code;
      end
      m_armado = (m_est == '0) || (m_armado && code == 0);
      m_est_prev = m_est;
      // a level is taken once the last DC synchronised samples all disagree with it
      m_hist.push_back(raw);
      for (int ch = 0; ch < N; ch++) begin
         todos = 1;
         for (int j = 0; j < DC; j++)
            if (m_hist[m_hist.size() - 3 - j][ch] == m_est[ch]) todos = 0;
         if (todos) m_est[ch] = m_hist[m_hist.size() - 3][ch];
      end
      while (m_hist.size() > DC + 3) void'(m_hist.pop_front());
   endfunction

   task automatic ciclo(input logic [N-1:0] raw, input logic ready);
      botones_raw  = raw;
      evento_ready = ready;
      if (evento_valid && ready) obs.push_back(int'(evento_codigo));
      @(posedge clk);
      model_edge(raw, ready);
      @(negedge clk);
      comprobar("valid", int'(evento_valid), int'(m_cola.size() > 0));
      comprobar("codigo", int'(evento_codigo), (m_cola.size() > 0) ? m_cola[0] : 0);
      comprobar("boton_pres", int'(boton_pres), m_pres);
      comprobar("pausa", int'(pausa_activa), int'(m_pausa));
      comprobar("rechazo", int'(rechazo), int'(m_rech));
      comprobar("desborde", int'(desborde), int'(m_desb));
      if (rechazo) vio_rech = 1;
      if (desborde) vio_desb = 1;
   endtask

   task automatic pulsar(input logic [N-1:0] mask, input logic ready);
      for (int k = 0; k < 12; k++) ciclo(mask, ready);
      for (int k = 0; k < 12; k++) ciclo('0, ready);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      comprobar("rst_valid", int'(evento_valid), 0);
      comprobar("rst_codigo", int'(evento_codigo), 0);
      comprobar("rst_boton_pres", int'(boton_pres), 0);
      comprobar("rst_pausa", int'(pausa_activa), 0);
      comprobar("rst_rechazo", int'(rechazo), 0);
      comprobar("rst_desborde", int'(desborde), 0);
      model_reset();
      obs.delete();
      vio_rech = 0; vio_desb = 0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic comprobar_cola(input string tag, input int n,
                                 input int e0, input int e1, input int e2, input int e3);
      int esp[4];
      esp = '{e0, e1, e2, e3};
      comprobar({tag, "_n"}, obs.size(), n);
      for (int i = 0; i < n; i++)
         comprobar(tag, (i < obs.size()) ? obs[i] : -1, esp[i]);
   endtask

   task automatic medir_latencia(input string tag, input logic [N-1:0] raw, input logic ready,
                                 input int hold, input int esp_cod);
      int lat, cod;
      lat = 0; cod = -1;
      for (int k = 1; k <= 20; k++) begin
         ciclo((k <= hold) ? raw : '0, ready);
         if (evento_valid && lat == 0) begin
            lat = k;
            cod = int'(evento_codigo);
         end
      end
      comprobar({tag, "_latencia"}, lat, 8);
      comprobar({tag, "_codigo"}, cod, esp_cod);
   endtask

   initial begin
      rst_n        = 1'b0;
      botones_raw  = '0;
      evento_ready = 1'b0;
      model_reset();
      @(negedge clk);
      do_reset();

      // 1: glitches are filtered, a held press yields one event 8 cycles after the edge
      ciclo(5'b00001, 1'b1);
      for (int k = 0; k < 3; k++) ciclo('0, 1'b1);
      ciclo(5'b00001, 1'b1);
      for (int k = 0; k < 3; k++) ciclo('0, 1'b1);
      obs.delete();
      medir_latencia("t1", 5'b00001, 1'b1, 10, 1);
      comprobar_cola("t1_eventos", 1, 1, 0, 0, 0);

      // 2: no press without release; reversal after release is rejected
      do_reset();
      for (int k = 0; k < 12; k++) ciclo(5'b00001, 1'b1);
      for (int k = 0; k < 12; k++) ciclo(5'b00011, 1'b1);
      for (int k = 0; k < 12; k++) ciclo('0, 1'b1);
      pulsar(5'b00010, 1'b1);
      comprobar_cola("t2_eventos", 1, 1, 0, 0, 0);
      comprobar("t2_rechazo", int'(vio_rech), 1);
      comprobar("t2_boton_pres", int'(boton_pres), 1);

      // 3: pause blocks directions and toggles back
      do_reset();
      pulsar(5'b10000, 1'b0);
      pulsar(5'b01000, 1'b0);
      comprobar("t3_pausa_on", int'(pausa_activa), 1);
      comprobar("t3_rechazo", int'(vio_rech), 1);
      pulsar(5'b10000, 1'b0);
      comprobar("t3_pausa_off", int'(pausa_activa), 0);
      for (int k = 0; k < 6; k++) ciclo('0, 1'b1);
      comprobar_cola("t3_eventos", 2, 5, 5, 0, 0);

      // 4: overflow of a stalled queue, then ordered drain
      do_reset();
      pulsar(5'b00001, 1'b0);
      pulsar(5'b00100, 1'b0);
      pulsar(5'b00001, 1'b0);
      pulsar(5'b01000, 1'b0);
      comprobar("t4_sin_desborde", int'(vio_desb), 0);
      pulsar(5'b00001, 1'b0);
      comprobar("t4_desborde", int'(vio_desb), 1);
      comprobar("t4_boton_pres", int'(boton_pres), 1);
      for (int k = 0; k < 8; k++) ciclo('0, 1'b1);
      comprobar_cola("t4_eventos", 4, 1, 3, 1, 4);

      // 5: simultaneous edges, lowest channel wins
      do_reset();
      pulsar(5'b01100, 1'b1);
      comprobar_cola("t5_eventos", 1, 3, 0, 0, 0);

      // 6: reset with queued events, button held through reset
      do_reset();
      pulsar(5'b00001, 1'b0);
      pulsar(5'b00100, 1'b0);
      comprobar("t6_encolados", int'(evento_valid), 1);
      botones_raw = 5'b00010;
      do_reset();
      medir_latencia("t6", 5'b00010, 1'b0, 20, 2);

      // random phase
      do_reset();
      for (int s = 0; s < 260; s++) begin
         logic [N-1:0] m;
         int len, pr;
         m   = ($urandom_range(0, 2) == 0) ? '0 : N'($urandom_range(1, 31));
         len = $urandom_range(1, 14);
         pr  = $urandom_range(0, 4);
         for (int c = 0; c < len; c++) ciclo(m, $urandom_range(0, 3) < pr);
         if ($urandom_range(0, 60) == 0) do_reset();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
